// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes, instruction classes and sequencer states
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [1:0] MDR_BUS = 2'b00;
  localparam logic [1:0] MDR_MEM = 2'b01;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_SHR = 4'd4, ALU_SHL = 4'd5, ALU_ROR = 4'd6, ALU_ROL = 4'd7,
    ALU_MUL = 4'd8, ALU_DIV = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11
  } alu_e;

  typedef enum logic [3:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU, CL_IMM, CL_MULDIV, CL_UNARY, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } iclass_e;

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_FETCH3,
    S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_HALT
  } state_e;

  // Final execute state of each class; execute states run T3 upward to it.
  function automatic state_e last_state(input iclass_e c);
    case (c)
      CL_LD:                  return S_T8;
      CL_ST:                  return S_T7;
      CL_MULDIV, CL_BR:       return S_T6;
      CL_LDI, CL_ALU, CL_IMM: return S_T5;
      CL_UNARY, CL_JAL:       return S_T4;
      default:                return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_op_decode.sv
// rtl/control_unit_op_decode.sv - opcode to instruction class and ALU operation
import cpu_pkg::*;

module op_decode (
  input  logic [4:0] opcode,
  output iclass_e    iclass,
  output alu_e       alu_op
);

  always_comb begin
    iclass = CL_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   iclass = CL_LD;
      OP_LDI:  iclass = CL_LDI;
      OP_ST:   iclass = CL_ST;
      OP_ADD:  begin iclass = CL_ALU;    alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = CL_ALU;    alu_op = ALU_SUB; end
      OP_AND:  begin iclass = CL_ALU;    alu_op = ALU_AND; end
      OP_OR:   begin iclass = CL_ALU;    alu_op = ALU_OR;  end
      OP_SHR:  begin iclass = CL_ALU;    alu_op = ALU_SHR; end
      OP_SHL:  begin iclass = CL_ALU;    alu_op = ALU_SHL; end
      OP_ROR:  begin iclass = CL_ALU;    alu_op = ALU_ROR; end
      OP_ROL:  begin iclass = CL_ALU;    alu_op = ALU_ROL; end
      OP_ADDI: begin iclass = CL_IMM;    alu_op = ALU_ADD; end
      OP_ANDI: begin iclass = CL_IMM;    alu_op = ALU_AND; end
      OP_ORI:  begin iclass = CL_IMM;    alu_op = ALU_OR;  end
      OP_MUL:  begin iclass = CL_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin iclass = CL_MULDIV; alu_op = ALU_DIV; end
      OP_NEG:  begin iclass = CL_UNARY;  alu_op = ALU_NEG; end
      OP_NOT:  begin iclass = CL_UNARY;  alu_op = ALU_NOT; end
      OP_BR:   iclass = CL_BR;
      OP_JR:   iclass = CL_JR;
      OP_JAL:  iclass = CL_JAL;
      OP_IN:   iclass = CL_IN;
      OP_OUT:  iclass = CL_OUT;
      OP_MFHI: iclass = CL_MFHI;
      OP_MFLO: iclass = CL_MFLO;
      OP_HALT: iclass = CL_HALT;
      default: iclass = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired multi-cycle sequencer driving the single-bus datapath strobes
import cpu_pkg::*;

module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        Branch,
  input  logic        stop,
  output logic        run,
  output logic        PCout, Zlowout, Zhighout, MDRout, HIout,
  output logic        LOout, InPortout, Cout, BAout, Rout,
  output logic        PCin, IRin, MARin, MDRin, Yin, Zin, Zlowin,
  output logic        Zhighin, HIin, LOin, OutPortin, InPortin, Rin,
  output logic        GRA, GRB, GRC,
  output logic        read, write, IncPc,
  output logic [1:0]  mdr_read,
  output logic [3:0]  control
);

  state_e  state_q, state_d;
  iclass_e class_q, class_d, dec_class;
  alu_e    alu_q, alu_d, dec_alu;
  logic    unused_ir;

  assign unused_ir = ^IR[26:0];

  op_decode u_op_decode (
    .opcode (IR[31:27]),
    .iclass (dec_class),
    .alu_op (dec_alu)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH0;
      class_q <= CL_NOP;
      alu_q   <= ALU_ADD;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      alu_q   <= alu_d;
    end
  end

  // The decoded class is latched on the FETCH3 edge so IR only has to be valid then.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    alu_d   = alu_q;
    unique case (state_q)
      S_FETCH0: if (!stop) state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: begin
        class_d = dec_class;
        alu_d   = dec_alu;
        state_d = (dec_class == CL_HALT) ? S_HALT : S_T3;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = (state_q == last_state(class_q)) ? S_FETCH0
                                                           : state_e'(state_q + 4'd1);
    endcase
  end

  always_comb begin
    run = 1'b1;
    {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, Zlowin, Zhighin, HIin, LOin, OutPortin, Rin} = '0;
    {GRA, GRB, GRC, read, write, IncPc} = '0;
    InPortin = 1'b1;
    mdr_read = MDR_BUS;
    control  = ALU_ADD;
    unique case (state_q)
      S_FETCH0: begin
        if (stop) run = 1'b0;
        else begin PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zin = 1'b1; Zlowin = 1'b1; end
      end
      S_FETCH1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; end
      S_FETCH2: begin read = 1'b1; mdr_read = MDR_MEM; MDRin = 1'b1; end
      S_FETCH3: begin MDRout = 1'b1; IRin = 1'b1; end
      S_HALT:   run = 1'b0;
      S_T3: begin
        case (class_q)
          CL_LD, CL_LDI, CL_ST: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_ALU, CL_IMM:       begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_MULDIV:            begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_UNARY: begin
            GRB = 1'b1; Rout = 1'b1; control = alu_q; Zin = 1'b1; Zlowin = 1'b1;
          end
          CL_BR:   begin GRA = 1'b1; Rout = 1'b1; end
          CL_JR:   begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CL_JAL:  begin PCout = 1'b1; GRB = 1'b1; Rin = 1'b1; end
          CL_IN:   begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_OUT:  begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          CL_MFHI: begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_MFLO: begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (class_q)
          CL_LD, CL_LDI, CL_ST: begin Cout = 1'b1; Zin = 1'b1; Zlowin = 1'b1; end
          CL_ALU: begin
            GRC = 1'b1; Rout = 1'b1; control = alu_q; Zin = 1'b1; Zlowin = 1'b1;
          end
          CL_IMM: begin Cout = 1'b1; control = alu_q; Zin = 1'b1; Zlowin = 1'b1; end
          CL_MULDIV: begin
            GRB = 1'b1; Rout = 1'b1; control = alu_q;
            Zin = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1;
          end
          CL_UNARY: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_BR:    begin PCout = 1'b1; Yin = 1'b1; end
          CL_JAL:   begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (class_q)
          CL_LD, CL_ST:           begin Zlowout = 1'b1; MARin = 1'b1; end
          CL_LDI, CL_ALU, CL_IMM: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CL_MULDIV:              begin Zlowout = 1'b1; LOin = 1'b1; end
          CL_BR:                  begin Cout = 1'b1; Zin = 1'b1; Zlowin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (class_q)
          CL_LD:     read = 1'b1;
          CL_ST:     begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CL_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          CL_BR:     begin Zlowout = 1'b1; PCin = Branch; end
          default: ;
        endcase
      end
      S_T7: begin
        case (class_q)
          CL_LD:   begin read = 1'b1; mdr_read = MDR_MEM; MDRin = 1'b1; end
          CL_ST:   write = 1'b1;
          default: ;
        endcase
      end
      S_T8: if (class_q == CL_LD) begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle hardwired sequencer that sits directly upstream of the single-bus datapath. It decodes the IR value returned by the datapath and drives every datapath control strobe, one Moore state per clock. The fetch/execute sequences it emits are the only legal way the datapath is exercised in the full CPU.

## Interface
Parameters: none. Opcodes and ALU codes come from the shared package.
- clk  in  1  single system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low forces state FETCH0 immediately
- IR  in  32  datapath IR value; opcode = IR[31:27]
- Branch  in  1  CON FF result from datapath
- stop  in  1  pause request, sampled only in FETCH0
- run  out  1  high unless paused or halted
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout  out  1 each  bus-drive strobes
- PCin, IRin, MARin, MDRin, Yin, Zin, Zlowin, Zhighin, HIin, LOin, OutPortin, InPortin, Rin  out  1 each  register-load strobes
- GRA, GRB, GRC  out  1 each  IR register-field selects
- read, write, IncPc  out  1 each  memory and PC-increment controls
- mdr_read  out  2  MDR source mux: 00 bus, 01 memory
- control  out  4  ALU operation code

## Operation
- Moore FSM: outputs are a pure function of state (plus Branch in BR6). Every strobe not listed for a state is 0; mdr_read=00, control=ADD by default. InPortin=1 in every state.
- Fetch: FETCH0 PCout MARin IncPc Zin Zlowin; FETCH1 Zlowout PCin read; FETCH2 read mdr_read=01 MDRin; FETCH3 MDRout IRin; then decode into T3 of the opcode class.
- Memory reads hold read for two cycles; MDRin is asserted on the second.
- ld: T3 GRB BAout Yin; T4 Cout ADD Zin Zlowin; T5 Zlowout MARin; T6 read; T7 read mdr_read=01 MDRin; T8 MDRout GRA Rin.
- ldi: T3–T4 as ld; T5 Zlowout GRA Rin.
- st: T3–T5 as ld; T6 GRA Rout MDRin (mdr_read=00); T7 write.
- ALU reg (add sub and or shr shl ror rol): T3 GRB Rout Yin; T4 GRC Rout control=op Zin Zlowin; T5 Zlowout GRA Rin.
- ALU imm (addi andi ori): same as ALU reg, with Cout replacing GRC Rout in T4.
- mul/div: T3 GRA Rout Yin; T4 GRB Rout control=op Zin Zlowin Zhighin; T5 Zlowout LOin; T6 Zhighout HIin.
- neg/not: T3 GRB Rout control=op Zin Zlowin; T4 Zlowout GRA Rin.
- br: T3 GRA Rout (CON FF evaluates); T4 PCout Yin; T5 Cout ADD Zin Zlowin; T6 Zlowout, and PCin=Branch.
- jr: T3 GRA Rout PCin.
- jal: T3 PCout GRB Rin (link register named in the Rb field); T4 GRA Rout PCin.
- in: T3 InPortout GRA Rin. out: T3 GRA Rout OutPortin. mfhi: T3 HIout GRA Rin. mflo: T3 LOout GRA Rin.
- nop, and any undefined opcode: return to FETCH0 with no strobes.
- halt: enter HALT. HALT is sticky, run=0 and all strobes are 0; only reset exits it.

## Timing
- Cycles per instruction (fetch 4 + execute): ld 10, ldi 7, st 9, ALU/imm 7, mul/div 8, neg/not 6, br 8, jr/out/in/mf 5, jal 6, nop 5.
- The last execute state always transitions to FETCH0.
- Pause: stop=1 in FETCH0 holds FETCH0 with all strobes 0 and run=0; fetch resumes the cycle after stop falls. stop is ignored in every other state, so an instruction is never split.
- Reset asserted mid-instruction aborts it: outputs drop to the FETCH0 pattern asynchronously. After reset release, the first edge performs FETCH0 actions. run=1 during reset.
- IR is sampled only in FETCH3→T3 decode and must be stable thereafter.

## Structure
- Package cpu_pkg holds the 5-bit opcodes: ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, shr 7, shl 8, ror 9, rol 10, addi 11, andi 12, ori 13, mul 14, div 15, neg 16, not 17, br 18, jr 19, jal 20, in 21, out 22, mfhi 23, mflo 24, nop 25, halt 26.
- cpu_pkg also holds the 4-bit ALU codes: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, ROR 6, ROL 7, MUL 8, DIV 9, NEG 10, NOT 11.
- cpu_pkg holds the state enum as well.
- One sub-module, op_decode: combinational IR[31:27] → instruction class + ALU code.

## Test plan
- Reset low mid-T4 of add → outputs immediately equal the FETCH0 pattern (PCout MARin IncPc Zlowin = 1); after release, FETCH0→FETCH3 strobes occur on 4 consecutive edges.
- IR=opcode 3 (add) → T3 GRB Rout Yin, T4 GRC Rout control=0 Zlowin, T5 Zlowout GRA Rin; next state FETCH0; total 7 cycles.
- IR=opcode 0 (ld) → read high in T6 and T7, MDRin with mdr_read=01 only in T7, GRA Rin in T8.
- br with Branch=0 then Branch=1 → PCin in T6 equals 0 and 1 respectively.
- stop=1 for 3 cycles at FETCH0 → run=0 and no strobes for 3 cycles, then FETCH1 follows; stop pulsed during T4 → no effect.
- IR=opcode 26 (halt) → HALT, run=0 forever; opcode 31 → behaves as nop (5 cycles).
